// File: rtl/jump_controller_if.sv
// Bus between the decode stage and the jump sequencer: ALU flags, decoded jump
// operation, stall, and the PC / flush / link results going back to the front end.
interface jump_controller_if #(
    parameter int ADDR_W = 16
);
    logic              flag_we;
    logic              O_in;
    logic              S_in;
    logic              C_in;
    logic              Z_in;
    logic              instr_valid;
    logic [2:0]        OP_TF;
    logic [2:0]        cond;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] reg_b;
    logic              stall;
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic              link_we;
    logic [ADDR_W-1:0] link_data;
    logic [3:0]        flags;

    modport master (
        output flag_we, O_in, S_in, C_in, Z_in,
        output instr_valid, OP_TF, cond, instr_pc, target, reg_b, stall,
        input  pc, flush, link_we, link_data, flags
    );

    modport slave (
        input  flag_we, O_in, S_in, C_in, Z_in,
        input  instr_valid, OP_TF, cond, instr_pc, target, reg_b, stall,
        output pc, flush, link_we, link_data, flags
    );
endinterface

// File: rtl/jump_controller.sv
// Branch/jump sequencer: owns the {O,S,C,Z} flag register and the PC, resolves
// jumps against the registered flags, flushes on taken transfers, writes link on jal.

// Condition/opcode evaluator. out=1 means the transfer is not taken.
module tester_flags (
    input  logic [3:0] flags,
    input  logic [2:0] cond,
    input  logic [2:0] op,
    output logic       out
);
    localparam logic [2:0] OP_JF  = 3'b000;
    localparam logic [2:0] OP_JT  = 3'b001;
    localparam logic [2:0] OP_J   = 3'b010;
    localparam logic [2:0] OP_JAL = 3'b011;
    localparam logic [2:0] OP_JR  = 3'b100;

    logic flag_o, flag_s, flag_c, flag_z;
    logic c;
    logic take;

    assign {flag_o, flag_s, flag_c, flag_z} = flags;

    always_comb begin
        c = 1'b0;
        case (cond)
            3'b000:  c = 1'b1;
            3'b001:  c = flag_s;
            3'b010:  c = flag_z;
            3'b100:  c = flag_c;
            3'b101:  c = flag_s | flag_z;
            3'b111:  c = flag_o;
            default: c = 1'b0;
        endcase
    end

    always_comb begin
        take = 1'b0;
        case (op)
            OP_JF:                take = ~c;
            OP_JT:                take = c;
            OP_J, OP_JAL, OP_JR:  take = 1'b1;
            default:              take = 1'b0;
        endcase
    end

    assign out = ~take;
endmodule

// state | meaning
// RUN   | normal fetch; jumps presented on the bus are evaluated
// FLUSH | first cycle(s) after a taken transfer; flush=1, jumps are discarded
module jump_controller #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic             clock,
    input  logic             reset,
    jump_controller_if.slave bus
);
    localparam logic [2:0] OP_JAL = 3'b011;
    localparam logic [2:0] OP_JR  = 3'b100;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              link_we_q, link_we_d;
    logic [ADDR_W-1:0] link_data_q, link_data_d;
    logic [3:0]        flags_q;
    logic              not_taken;
    logic              taken;
    logic [ADDR_W-1:0] dest;

    tester_flags u_tester_flags (
        .flags (flags_q),
        .cond  (bus.cond),
        .op    (bus.OP_TF),
        .out   (not_taken)
    );

    assign taken = bus.instr_valid & ~not_taken & (state_q == RUN);
    assign dest  = (bus.OP_TF == OP_JR) ? bus.reg_b : bus.target;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        link_we_d   = 1'b0;
        link_data_d = link_data_q;
        case (state_q)
            RUN: begin
                if (!bus.stall) begin
                    if (taken) begin
                        pc_d    = dest;
                        state_d = FLUSH;
                        if (bus.OP_TF == OP_JAL) begin
                            link_we_d   = 1'b1;
                            link_data_d = bus.instr_pc + ADDR_W'(1);
                        end
                    end else begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (!bus.stall) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RUN;
            pc_q        <= RESET_PC;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            link_we_q   <= link_we_d;
            link_data_q <= link_data_d;
        end
    end

    // Flags load regardless of stall/state; jumps in the same cycle see the old value.
    always_ff @(posedge clock) begin
        if (reset) begin
            flags_q <= 4'b0000;
        end else if (bus.flag_we) begin
            flags_q <= {bus.O_in, bus.S_in, bus.C_in, bus.Z_in};
        end
    end

    assign bus.pc        = pc_q;
    assign bus.flush     = (state_q == FLUSH);
    assign bus.link_we   = link_we_q;
    assign bus.link_data = link_data_q;
    assign bus.flags     = flags_q;
endmodule

// File: doc/jump_controller.md
# jump_controller

Branch and jump sequencer for the processor front end. It holds the architectural flag register (O, S, C, Z) and the program counter. Each cycle it evaluates the decoded jump operation against the registered flags through an internal `tester_flags` instance. It then selects the next PC, issues a one-cycle pipeline flush on taken transfers, and writes the link register for `jal`.

## Interface
- `ADDR_W`, 16, width of PC, targets and link data
- `RESET_PC`, 0, PC value loaded by reset
- `clock`  in  1  single system clock, rising edge
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clock`
- `flag_we`  in  1  load `O_in`/`S_in`/`C_in`/`Z_in` into the flag register
- `O_in`, `S_in`, `C_in`, `Z_in`  in  1 each  ALU flag results
- `instr_valid`  in  1  decode stage holds a valid jump-class instruction
- `OP_TF`  in  3  jump op: 111 none, 000 jf, 001 jt, 010 j, 011 jal, 100 jr; others act as none
- `cond`  in  3  condition: 000 true, 001 neg (S), 010 zero (Z), 100 carry (C), 101 negzero (S|Z), 111 overflow (O); 011/110 evaluate false
- `instr_pc`  in  ADDR_W  address of the instruction in decode
- `target`  in  ADDR_W  immediate destination for jf/jt/j/jal
- `reg_b`  in  ADDR_W  register destination for jr
- `stall`  in  1  freeze PC and state this cycle
- `pc`  out  ADDR_W  current fetch address, registered
- `flush`  out  1  kill instruction in fetch/decode, registered
- `link_we`  out  1  write `link_data` to link register, one-cycle pulse
- `link_data`  out  ADDR_W  `instr_pc + 1`, registered with `link_we`
- `flags`  out  4  {O,S,C,Z}, registered

## Operation
- Flag register: loads when `flag_we`=1, independent of `stall` and FSM state. A jump in the same cycle as `flag_we` uses the old (registered) flags.
- Condition value `c` comes from `cond` and the registered flags.
  - jt is taken when `c`=1; jf is taken when `c`=0.
  - j, jal and jr are always taken.
  - none is never taken.
- The internal `tester_flags` output `out`=1 means not taken; `taken = instr_valid & ~out & (state==RUN)`.
- Destination is `reg_b` for jr and `target` otherwise.
- FSM states:
  - RUN: if `stall`, hold everything. Else if `taken`: `pc`<=dest, go to FLUSH. Else `pc`<=`pc+1`.
  - FLUSH: `flush`=1. `instr_valid` is ignored. If `stall`, hold. Else `pc`<=`pc+1` and go to RUN.
- jal: when taken in RUN, `link_we`<=1 and `link_data`<=`instr_pc+1` for exactly the next cycle. jf, jt, j and jr never assert `link_we`.
- PC arithmetic is modulo 2^ADDR_W: `pc+1` wraps from all-ones to 0, and `instr_pc+1` wraps the same way.

## Timing
- Reset values: `pc`=RESET_PC, `flags`=0000, `flush`=0, `link_we`=0, `link_data`=0, state=RUN.
- Reset mid-FLUSH or mid-stall returns to RUN at once. No pending link write survives reset.
- Taken decision to new `pc`: 1 cycle. `flush` is high in the same cycle as the new `pc` and stays high while FLUSH is held by `stall`.
- `link_we` is high in the same cycle as the new `pc`, for 1 cycle only, even if `stall` rises.
- `flag_we` to new `flags`: 1 cycle. A jump may see the new flags from the following cycle.
- Back-to-back jumps: the second jump, presented during FLUSH, is discarded; only a jump presented in RUN is evaluated.
- Stall in RUN with `instr_valid`=1: no evaluation. The instruction is re-evaluated when `stall` drops, using the flags current at that time.

## Test plan
- Reset, then 3 free cycles → `pc` = 0,1,2,3; `flush`=0; `flags`=0000.
- `flag_we` with Z=1; next cycle jt/zero, `target`=0x0040 → `pc`=0x0040 one cycle later; `flush`=1 for 1 cycle; then `pc`=0x0041.
- jf/carry with C=1 → not taken, `pc` increments, `flush`=0. Repeat with C=0 → jump to `target`.
- jal, `instr_pc`=0x0010, `target`=0x0100 → `pc`=0x0100, `link_we`=1, `link_data`=0x0011 for one cycle. jr with `reg_b`=0x0011 → `pc`=0x0011, `link_we`=0.
- Taken j with `stall` high during FLUSH for 2 cycles, plus a second j presented in FLUSH → `flush` held 3 cycles, `pc` held at the first target, second jump ignored.
- `pc`=0xFFFF free-running → wraps to 0x0000. Assert `reset` while in FLUSH → next cycle `pc`=RESET_PC, `flush`=0, `flags`=0000.
